// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm
//   Multi-cycle control unit for the 16-opcode ISA. Sequences
//   IDLE -> FETCH -> EXEC [-> MEM] -> FETCH, with HALT reached on the EOE
//   instruction or on a bus timeout. Control outputs are combinational from
//   state, opcode and the ready strobes. State, wait counter, bus_err and
//   retired are registered.
//
// Handshake semantics: IL (instruction) and dmem_req (data) act as valid.
//   Each one stays high for every cycle the controller sits in FETCH or MEM.
//   imem_ready / dmem_ready act as ready. A transfer completes in the cycle
//   where request and ready are both high, and the state advances on the
//   following edge. A request is withdrawn early only on timeout or reset.
//
// Ports:
//   clk, reset (async, active-low)
//   opcode, Rd                 decoded instruction fields
//   imem_ready, dmem_ready     memory completion strobes
//   resume                     leave HALT
//   FS, PS, MB, resultSource, RW, MW, BC, IL, dmem_req, EOE   control word
//   bus_err                    sticky wait-state timeout flag
//   retired                    completed-instruction count (wraps)
//   state_dbg                  current FSM state encoding
module cpu_control_fsm #(
  parameter int FS_W     = 3,
  parameter int RD_W     = 4,
  parameter int WAIT_W   = 4,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        opcode,
  input  logic [RD_W-1:0]   Rd,
  input  logic              imem_ready,
  input  logic              dmem_ready,
  input  logic              resume,
  output logic [FS_W-1:0]   FS,
  output logic [1:0]        PS,
  output logic              MB,
  output logic [1:0]        resultSource,
  output logic              RW,
  output logic              MW,
  output logic [1:0]        BC,
  output logic              IL,
  output logic              dmem_req,
  output logic              EOE,
  output logic              bus_err,
  output logic [CNT_W-1:0]  retired,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  localparam logic [3:0] OP_LI  = 4'd8;
  localparam logic [3:0] OP_LW  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;
  localparam logic [3:0] OP_BIZ = 4'd11;
  localparam logic [3:0] OP_BNZ = 4'd12;
  localparam logic [3:0] OP_JAL = 4'd13;
  localparam logic [3:0] OP_JMP = 4'd14;

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  state_t            state, next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_inc;
  logic              set_err;
  logic              clr_err;
  logic              retire;

  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      bus_err  <= 1'b0;
      retired  <= '0;
    end else begin
      state <= next_state;
      // Any state change restarts the count, so FETCH and MEM always begin at 0.
      if (next_state != state) begin
        wait_cnt <= '0;
      end else if (wait_inc) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (set_err) begin
        bus_err <= 1'b1;
      end else if (clr_err) begin
        bus_err <= 1'b0;
      end
      if (retire) begin
        retired <= retired + 1'b1;
      end
    end
  end

  always_comb begin
    next_state   = state;
    FS           = '0;
    PS           = 2'd0;
    MB           = 1'b0;
    resultSource = 2'd0;
    RW           = 1'b0;
    MW           = 1'b0;
    BC           = 2'd3;
    IL           = 1'b0;
    dmem_req     = 1'b0;
    EOE          = 1'b0;
    wait_inc     = 1'b0;
    set_err      = 1'b0;
    clr_err      = 1'b0;
    retire       = 1'b0;

    unique case (state)
      ST_IDLE: begin
        next_state = ST_FETCH;
      end

      ST_FETCH: begin
        IL = 1'b1;
        // Ready is checked before the limit so a late ready still succeeds.
        if (imem_ready) begin
          PS         = 2'd1;
          next_state = ST_EXEC;
        end else if (wait_cnt == WAIT_LIMIT) begin
          set_err    = 1'b1;
          next_state = ST_HALT;
        end else begin
          wait_inc = 1'b1;
        end
      end

      ST_EXEC: begin
        if (!opcode[3]) begin
          FS         = FS_W'(opcode[2:0]);
          RW         = 1'b1;
          next_state = ST_FETCH;
        end else begin
          unique case (opcode)
            OP_LI: begin
              MB           = 1'b1;
              resultSource = 2'd3;
              RW           = 1'b1;
              next_state   = ST_FETCH;
            end
            OP_LW, OP_SW: next_state = ST_MEM;
            OP_BIZ: begin
              PS         = 2'd2;
              BC         = 2'd0;
              next_state = ST_FETCH;
            end
            OP_BNZ: begin
              PS         = 2'd2;
              BC         = 2'd1;
              next_state = ST_FETCH;
            end
            OP_JAL: begin
              PS           = 2'd2;
              resultSource = 2'd1;
              RW           = 1'b1;
              next_state   = ST_FETCH;
            end
            OP_JMP: begin
              PS         = 2'd2;
              next_state = ST_FETCH;
            end
            default: begin
              // Opcode 15: Rd selects JR, EOE or NOP.
              if (Rd == '0) begin
                PS         = 2'd3;
                next_state = ST_FETCH;
              end else if (&Rd) begin
                next_state = ST_HALT;
              end else begin
                next_state = ST_FETCH;
              end
            end
          endcase
        end
        // Loads/stores retire in MEM. EOE is never counted.
        retire = (next_state == ST_FETCH);
      end

      ST_MEM: begin
        dmem_req     = 1'b1;
        resultSource = 2'd2;
        if (dmem_ready) begin
          if (opcode == OP_SW) begin
            MW = 1'b1;
          end else begin
            RW = 1'b1;
          end
          retire     = 1'b1;
          next_state = ST_FETCH;
        end else if (wait_cnt == WAIT_LIMIT) begin
          set_err    = 1'b1;
          next_state = ST_HALT;
        end else begin
          wait_inc = 1'b1;
        end
      end

      ST_HALT: begin
        EOE = 1'b1;
        if (resume) begin
          clr_err    = 1'b1;
          next_state = ST_FETCH;
        end
      end

      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

endmodule

// File: doc/cpu_control_fsm.md
Name: cpu_control_fsm

Overview:
Parametrised multi-cycle control unit, successor to the two-state fetch/execute controller. Uses the same 16-opcode ISA and the same control-word outputs. Adds ready/valid handshakes for instruction and data memory, a bounded wait-state timeout with a sticky bus error, a halt state with resume, and a retired-instruction counter. Sits between the instruction register and the datapath (PC unit, register file, ALU, memories).

Parameters:
FS_W, 3, ALU function-select width; FS carries opcode[2:0] zero-extended.
RD_W, 4, destination-register field width.
WAIT_W, 4, wait-counter width.
MAX_WAIT, 15, last allowed wait cycle index; must be <= 2^WAIT_W-1.
CNT_W, 16, retired-instruction counter width.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
opcode  in  4  from instruction register; stable outside FETCH.
Rd  in  RD_W  destination field.
imem_ready  in  1  instruction word available this cycle.
dmem_ready  in  1  data access completes this cycle.
resume  in  1  leave HALT.
FS  out  FS_W  ALU function select.
PS  out  2  0 hold, 1 increment, 2 relative jump, 3 absolute jump.
MB  out  1  select immediate B.
resultSource  out  2  0 F, 1 PC, 2 RAM, 3 immediate.
RW  out  1  register-file write.
MW  out  1  memory write.
BC  out  2  0 zero, 1 nonzero, 3 always.
IL  out  1  instruction load.
dmem_req  out  1  data-memory request.
EOE  out  1  end of execution (halted).
bus_err  out  1  sticky timeout flag.
retired  out  CNT_W  completed-instruction count.

Behaviour:
- States: IDLE, FETCH, EXEC, MEM, HALT. Control outputs are combinational from state, opcode and the ready inputs. State, wait counter, bus_err and retired are registered.
- Defaults, asserted in IDLE and on every asynchronous reset: FS=0, PS=0, MB=0, resultSource=0, RW=0, MW=0, BC=3, IL=0, dmem_req=0, EOE=0, bus_err=0, retired=0, wait counter=0.
- Reset asserted mid-operation: forces IDLE immediately; no MW or RW pulse may occur.
- IDLE: after reset release, unconditionally moves to FETCH on the next edge.
- FETCH: IL=1 for the whole state.
  - With imem_ready=1: PS=1 that cycle, and the next state is EXEC.
  - Otherwise PS=0 and the wait counter increments.
- EXEC, decoded by opcode:
  - Opcodes 0-7: FS=opcode[2:0], RW=1, next state FETCH.
  - 8 (LI): MB=1, resultSource=3, RW=1, next state FETCH.
  - 9 (LW) and 10 (SW): all outputs at default, next state MEM.
  - 11 (BIZ): PS=2, BC=0, next state FETCH.
  - 12 (BNZ): PS=2, BC=1, next state FETCH.
  - 13 (JAL): PS=2, resultSource=1, RW=1, next state FETCH.
  - 14 (JMP): PS=2, next state FETCH.
  - 15 with Rd=0 (JR): PS=3, next state FETCH.
  - 15 with Rd all-ones (EOE): next state HALT; this instruction is not counted.
  - 15 with any other Rd: NOP, next state FETCH.
- MEM: dmem_req=1, resultSource=2.
  - LW: RW=1 only in the cycle where dmem_ready=1.
  - SW: MW=1 only in the cycle where dmem_ready=1.
  - On dmem_ready the next state is FETCH; otherwise the wait counter increments.
- Wait counter and timeout:
  - The counter clears on entering FETCH or MEM.
  - If the counter equals MAX_WAIT and the matching ready is 0, bus_err is set and the next state is HALT.
  - If ready arrives in that same cycle, ready wins.
  - MAX_WAIT=0 therefore requires ready in the first cycle of the state.
- HALT: EOE=1, PS=0, all other outputs at default.
  - resume=1 moves to FETCH and clears bus_err.
  - resume is ignored in every other state.
- retired: increments by 1 on each instruction completion, i.e. an EXEC→FETCH transition or a MEM completion. It wraps from 2^CNT_W-1 to 0 and is never cleared except by reset.

Test Plan:
- Reset then opcode=0 (ADD), imem_ready=1 continuously: IDLE→FETCH (IL=1, PS=1)→EXEC (RW=1, FS=0)→FETCH; retired=1 after 3 edges.
- SW with dmem_ready arriving on the 4th MEM cycle, MAX_WAIT=15: dmem_req=1 for 4 cycles, MW=1 only in the 4th, RW=0 throughout, then FETCH; retired increments once.
- LW with dmem_ready never asserted, MAX_WAIT=3: bus_err=1 and HALT after 4 MEM cycles; EOE=1, no RW pulse. resume=1 → FETCH with bus_err=0.
- opcode=15, Rd=4'hF: HALT with EOE=1 and PS=0, retired unchanged; resume held low 10 cycles keeps HALT; resume=1 → FETCH, EOE=0.
- Branches: BIZ gives PS=2/BC=0; BNZ gives PS=2/BC=1; JAL gives PS=2/resultSource=1/RW=1; JR (Rd=0) gives PS=3/RW=0; opcode 15 with Rd=5 gives all defaults.
- Reset asserted in the middle of a MEM wait: all outputs at defaults in the same cycle with no MW pulse. CNT_W=4 with 17 ADDs executed gives retired=1 (wrap).
